// File: rtl/cdb_arbiter.sv
// Rotating-priority arbiter and registered broadcast stage for the common data bus.
// Optional stall counter output enabled by defining CDB_STALL_CNT_EN.
module cdb_arbiter #(
   parameter int unsigned N_REQ = 5,
   parameter int unsigned TAG_W = 5,
   parameter int unsigned VAL_W = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       in_request,
   input  logic [N_REQ*TAG_W-1:0] in_tag,
   input  logic [N_REQ*VAL_W-1:0] in_val,
   output logic [N_REQ-1:0]       out_grant,
   output logic                   out_broadcast,
   output logic [TAG_W-1:0]       out_tag,
`ifdef CDB_STALL_CNT_EN
   output logic [15:0]            out_stall_cnt,
`endif
   output logic [VAL_W-1:0]       out_val
);

   localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0] grant_q, grant_d;
   logic             bcast_q, bcast_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [VAL_W-1:0] val_q, val_d;
   logic [PtrW-1:0]  ptr_q, ptr_d;

   logic [N_REQ-1:0] elig;
   logic             win_found;
   logic [PtrW-1:0]  win_idx;
   int unsigned      idx;
   int unsigned      nxt;

   // The unit currently holding the bus is masked so it cannot win twice in a row.
   always_comb begin
      elig      = in_request & ~grant_q;
      win_found = 1'b0;
      win_idx   = '0;
      idx       = 0;
      for (int unsigned off = 0; off < N_REQ; off++) begin
         idx = (32'(ptr_q) + off) % N_REQ;
         if (!win_found && elig[idx]) begin
            win_found = 1'b1;
            win_idx   = PtrW'(idx);
         end
      end
      nxt = (32'(win_idx) + 32'd1) % N_REQ;
   end

   always_comb begin
      grant_d = '0;
      bcast_d = 1'b0;
      tag_d   = tag_q;
      val_d   = val_q;
      ptr_d   = ptr_q;
      if (win_found) begin
         grant_d[win_idx] = 1'b1;
         bcast_d          = 1'b1;
         tag_d            = in_tag[win_idx*TAG_W +: TAG_W];
         val_d            = in_val[win_idx*VAL_W +: VAL_W];
         ptr_d            = PtrW'(nxt);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_q <= '0;
         bcast_q <= 1'b0;
         tag_q   <= '0;
         val_q   <= '0;
         ptr_q   <= '0;
      end else begin
         grant_q <= grant_d;
         bcast_q <= bcast_d;
         tag_q   <= tag_d;
         val_q   <= val_d;
         ptr_q   <= ptr_d;
      end
   end

`ifdef CDB_STALL_CNT_EN
   logic [15:0] stall_q, stall_d;

   // Two or more eligible units means at least one lost this edge.
   always_comb begin
      stall_d = stall_q;
      if (($countones(elig) >= 2) && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign out_stall_cnt = stall_q;
`endif

   assign out_grant     = grant_q;
   assign out_broadcast = bcast_q;
   assign out_tag       = tag_q;
   assign out_val       = val_q;

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Rotating-priority arbiter and broadcast register for the Tomasulo common data bus. Five functional-unit requesters (add, logic, mul, load, store) raise a request with a result tag and value. Each cycle the arbiter selects at most one requester and drives the registered broadcast seen by reservation stations and the register-status table. It returns a one-cycle grant pulse to the winning unit so the unit can retire its result.

Parameters:
N_REQ, 5, number of requesters; index 0=add, 1=logic, 2=mul, 3=load, 4=store
TAG_W, 5, reservation-station tag width
VAL_W, 32, result value width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_request  in  N_REQ  per-unit request, bit i = unit i
in_tag  in  N_REQ*TAG_W  packed tags, unit i at [i*TAG_W +: TAG_W]
in_val  in  N_REQ*VAL_W  packed values, unit i at [i*VAL_W +: VAL_W]
out_grant  out  N_REQ  one-hot grant pulse, registered
out_broadcast  out  1  broadcast valid, registered
out_tag  out  TAG_W  broadcast tag
out_val  out  VAL_W  broadcast value

Behaviour:
- Reset: asynchronous, takes effect immediately, including mid-broadcast.
  - out_grant=0, out_broadcast=0, out_tag=0, out_val=0.
  - Priority pointer ptr=0.
- Eligible set each cycle: elig = in_request & ~out_grant.
  - A unit whose grant is currently high cannot win again in the same cycle.
- Winner: first set bit of elig scanning circularly from ptr upward (ptr, ptr+1, ... wrapping N_REQ-1 -> 0).
- At the rising edge, if elig != 0:
  - out_broadcast <= 1.
  - out_grant <= one-hot(winner).
  - out_tag/out_val <= winner's in_tag/in_val, sampled at that edge.
  - ptr <= (winner+1) mod N_REQ.
- At the rising edge, if elig == 0:
  - out_broadcast <= 0 and out_grant <= 0.
  - out_tag/out_val hold their last values.
  - ptr holds.
- Latency: a request present before edge k is broadcast during cycle k→k+1 at the earliest. Grant and broadcast are asserted in the same cycle.
- Requester contract:
  - Hold request/tag/val stable until its grant is seen.
  - On the edge ending the grant cycle, drop request or present the next result.
  - Tag/val changes while ungranted are legal; the value sampled at the winning edge is broadcast.
- Throughput:
  - Different units can be broadcast back to back, one per cycle.
  - The same unit can be broadcast at most every other cycle because of the masking rule.
- Fairness: with every unit requesting continuously, each unit wins at least once per N_REQ cycles. No starvation.
- A unit dropping its request before being granted is legal and is simply skipped.
- The out_grant one-hot invariant holds at all times. out_broadcast == |out_grant at all times.

Optional Feature:
Macro CDB_STALL_CNT_EN.
- When defined, adds output out_stall_cnt (16 bits).
  - Reset to 0.
  - Increments by 1 on each rising edge where popcount(elig) >= 2, i.e. at least one eligible unit lost arbitration.
  - Saturates at 16'hFFFF.
- When undefined, the port and counter do not exist and behaviour is otherwise identical.

Test Plan:
- Reset then a single request: release rst_n; logic raises req with tag=3, val=7 before edge 1.
  - Cycle after edge 1: out_broadcast=1, out_tag=3, out_val=7, out_grant=5'b00010.
  - Unit drops req; next cycle out_broadcast=0 and tag/val hold 3/7.
- Simultaneous contention: after the above (ptr=2), add (tag 5, val 1) and load (tag 9, val 15) request together.
  - Load broadcasts first (tag 9, grant 5'b01000).
  - Add broadcasts the next cycle (tag 5, grant 5'b00001).
  - No idle cycle between them.
- Full contention: all five units hold requests for 10 cycles with ptr=0.
  - Grant order 0,1,2,3,4,0,1,2,3,4.
  - out_broadcast=1 every cycle.
- Same-unit masking: only mul requests, and it holds req high for 4 cycles without changing tag.
  - Grant pattern 1,0,1,0 on bit 2.
  - Never two consecutive grants.
- Reset mid-operation: pull rst_n low asynchronously while out_broadcast=1 with tag 9.
  - All outputs go to 0 before the next clk edge.
  - After release with add requesting, add wins, since ptr returned to 0.
- With CDB_STALL_CNT_EN: three units request for one edge, then two units for one edge.
  - out_stall_cnt=2.
  - A single requester afterwards leaves it at 2.
